sensor_conditioner: RTL and testbench

SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

---
 rtl/sensor_conditioner.sv | 101 ++++++++++
 tb/tb_sensor_conditioner.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sensor_conditioner.sv
// Conditions three loop-detector inputs into controller demand signals:
// synchronize, debounce, latch a call until green, and flag stuck-on detectors.
module sensor_conditioner #(
  parameter int unsigned DEBOUNCE = 4,
  parameter logic [15:0] MAXON    = 16'd1000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Raw1,
  input  logic       Raw2,
  input  logic       Raw3,
  input  logic [1:0] L1,
  input  logic [1:0] L2,
  input  logic [1:0] L3,
  output logic       S1,
  output logic       S2,
  output logic       S3,
  output logic [2:0] Fault
);

  localparam logic [1:0]  GREEN     = 2'b01;
  localparam logic [3:0]  DB_LAST   = 4'(DEBOUNCE - 1);
  localparam logic [15:0] MAXON_M1  = MAXON - 16'd1;

  logic [2:0] raw_all;
  logic [5:0] l_all;
  logic [2:0] s_vec;
  logic [2:0] fault_vec;

  assign raw_all = {Raw3, Raw2, Raw1};
  assign l_all   = {L3, L2, L1};

  for (genvar i = 0; i < 3; i++) begin : g_ch
    logic        sync1;
    logic        raw_s;
    logic        det;
    logic [3:0]  cnt;
    logic        call;
    logic [15:0] ontime;
    logic        fault;
    logic        s_q;
    logic [1:0]  light;

    assign light = l_all[2*i +: 2];

    always_ff @(posedge Clock) begin
      if (Reset) begin
        sync1  <= 1'b0;
        raw_s  <= 1'b0;
        det    <= 1'b0;
        cnt    <= 4'd0;
        call   <= 1'b0;
        ontime <= 16'd0;
        fault  <= 1'b0;
        s_q    <= 1'b0;
      end else begin
        sync1 <= raw_all[i];
        raw_s <= sync1;

        // A level must disagree with det for DEBOUNCE consecutive edges to flip it.
        if (raw_s == det) begin
          cnt <= 4'd0;
        end else if (cnt == DB_LAST) begin
          det <= raw_s;
          cnt <= 4'd0;
        end else begin
          cnt <= cnt + 4'd1;
        end

        // Green serves the demand, so clearing wins over a fresh detection.
        if (light == GREEN) begin
          call <= 1'b0;
        end else if (det) begin
          call <= 1'b1;
        end

        if (!det) begin
          ontime <= 16'd0;
        end else if (ontime != MAXON) begin
          ontime <= ontime + 16'd1;
        end

        // Set on the edge ontime becomes MAXON; only Reset clears it.
        if (det && (ontime == MAXON_M1)) begin
          fault <= 1'b1;
        end

        s_q <= det | call | fault;
      end
    end

    assign s_vec[i]     = s_q;
    assign fault_vec[i] = fault;
  end

  assign S1    = s_vec[0];
  assign S2    = s_vec[1];
  assign S3    = s_vec[2];
  assign Fault = fault_vec;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner with DEBOUNCE = 4, MAXON = 20;
// inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_sensor_conditioner;

  localparam logic [1:0] GREEN  = 2'b01;
  localparam logic [1:0] YELLOW = 2'b10;
  localparam logic [1:0] RED    = 2'b11;
  localparam logic [1:0] INVAL  = 2'b00;

  logic       clock;
  logic       reset;
  logic       raw1, raw2, raw3;
  logic [1:0] l1, l2, l3;
  logic       s1, s2, s3;
  logic [2:0] fault;

  int checks   = 0;
  int failures = 0;

  sensor_conditioner #(
    .DEBOUNCE(4),
    .MAXON   (16'd20)
  ) dut (
    .Clock(clock),
    .Reset(reset),
    .Raw1 (raw1),
    .Raw2 (raw2),
    .Raw3 (raw3),
    .L1   (l1),
    .L2   (l2),
    .L3   (l3),
    .S1   (s1),
    .S2   (s2),
    .S3   (s3),
    .Fault(fault)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance n rising edges, then settle 1 unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    raw1 = 1'b0; raw2 = 1'b0; raw3 = 1'b0;
    l1 = RED; l2 = RED; l3 = RED;
    tick(2);
    check("reset_s", 16'({s3, s2, s1}), 16'h0);
    check("reset_fault", 16'(fault), 16'h0);
    reset = 1'b0;
    tick(2);
    check("idle_s", 16'({s3, s2, s1}), 16'h0);

    // Channel 1: debounce latency, call latch, release on green.
    raw1 = 1'b1;
    tick(6);
    check("c1_edge5_s1", 16'(s1), 16'h0);
    tick(1);
    check("c1_edge6_s1", 16'(s1), 16'h1);
    raw1 = 1'b0;
    tick(12);
    check("c1_call_hold", 16'(s1), 16'h1);
    l1 = GREEN;
    tick(1);
    check("c1_green_edge1", 16'(s1), 16'h1);
    tick(1);
    check("c1_green_edge2", 16'(s1), 16'h0);
    l1 = YELLOW;
    tick(3);
    check("c1_yellow_idle", 16'(s1), 16'h0);
    l1 = RED;

    // Channel 2: a 3-cycle pulse is rejected.
    raw2 = 1'b1;
    tick(3);
    raw2 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      check("c2_short_pulse", 16'(s2), 16'h0);
    end
    // A 4-cycle pulse is accepted and latches a call.
    raw2 = 1'b1;
    tick(4);
    raw2 = 1'b0;
    tick(2);
    check("c2_pulse4_edge5", 16'(s2), 16'h0);
    tick(1);
    check("c2_pulse4_edge6", 16'(s2), 16'h1);
    tick(8);
    check("c2_call_hold", 16'(s2), 16'h1);
    l2 = GREEN;
    tick(2);
    check("c2_green_clear", 16'(s2), 16'h0);
    l2 = RED;

    // Channel 3: presence under green never latches a call.
    l3 = GREEN;
    raw3 = 1'b1;
    tick(6);
    check("c3_edge5_s3", 16'(s3), 16'h0);
    tick(1);
    check("c3_edge6_s3", 16'(s3), 16'h1);
    tick(4);
    check("c3_hold", 16'(s3), 16'h1);
    raw3 = 1'b0;
    tick(6);
    check("c3_fall_edge5", 16'(s3), 16'h1);
    tick(1);
    check("c3_fall_edge6", 16'(s3), 16'h0);
    l3 = RED;

    // All channels together with mixed lights; 00 acts as red.
    l1 = RED; l2 = GREEN; l3 = INVAL;
    raw1 = 1'b1; raw2 = 1'b1; raw3 = 1'b1;
    tick(6);
    check("mix_edge5", 16'({s3, s2, s1}), 16'h0);
    tick(1);
    check("mix_edge6", 16'({s3, s2, s1}), 16'h7);
    raw1 = 1'b0; raw2 = 1'b0; raw3 = 1'b0;
    tick(6);
    check("mix_fall_edge5", 16'({s3, s2, s1}), 16'h7);
    tick(1);
    check("mix_fall_edge6", 16'({s3, s2, s1}), 16'h5);
    l1 = GREEN; l3 = GREEN;
    tick(2);
    check("mix_green_clear", 16'({s3, s2, s1}), 16'h0);
    l1 = RED; l2 = RED; l3 = RED;
    tick(2);

    // Reset mid-debounce on channel 2 while channel 1 is asserted.
    raw1 = 1'b1;
    tick(4);
    raw2 = 1'b1;
    tick(4);
    check("rst_pre_s1", 16'(s1), 16'h1);
    raw1 = 1'b0;
    reset = 1'b1;
    tick(1);
    check("rst_mid_s", 16'({s3, s2, s1}), 16'h0);
    check("rst_mid_fault", 16'(fault), 16'h0);
    reset = 1'b0;
    tick(6);
    check("rst_after_edge5", 16'(s2), 16'h0);
    tick(1);
    check("rst_after_edge6", 16'(s2), 16'h1);
    check("rst_after_s1", 16'(s1), 16'h0);
    raw2 = 1'b0;
    pulse_reset();
    tick(2);
    check("rst_clean", 16'({s3, s2, s1}), 16'h0);

    // Channel 1 stuck on: fault latches, forces demand, clears only on reset.
    raw1 = 1'b1;
    tick(20);
    check("flt_before", 16'(fault), 16'h0);
    tick(10);
    check("flt_set", 16'(fault), 16'h1);
    raw1 = 1'b0;
    l1 = GREEN;
    tick(12);
    check("flt_s1_forced", 16'(s1), 16'h1);
    check("flt_sticky", 16'(fault), 16'h1);
    check("flt_others", 16'({s3, s2}), 16'h0);
    reset = 1'b1;
    tick(1);
    check("flt_reset_fault", 16'(fault), 16'h0);
    check("flt_reset_s", 16'({s3, s2, s1}), 16'h0);
    reset = 1'b0;
    tick(3);
    check("flt_after_fault", 16'(fault), 16'h0);
    check("flt_after_s1", 16'(s1), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
